// File: rtl/seq_signed_divider_pkg.sv
// Shared arithmetic definitions for the sequential divider and its neighbours in the datapath.
// Holds state encodings, the default width and the fixed result patterns.
package seq_signed_divider_pkg;

   localparam int unsigned DEFAULT_W = 32;
   localparam int unsigned ST_W      = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_PREP  = 3'd1;
   localparam logic [ST_W-1:0] ST_ITER  = 3'd2;
   localparam logic [ST_W-1:0] ST_FIXUP = 3'd3;
   localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

   localparam logic [DEFAULT_W-1:0] DIV0_QUOTIENT = '1;
   localparam logic [DEFAULT_W-1:0] OVF_QUOTIENT  = {1'b1, {(DEFAULT_W-1){1'b0}}};

   typedef struct packed {
      logic div_by_zero;
      logic overflow;
   } div_flags_t;

endpackage

// File: rtl/seq_signed_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential signed divider.
interface seq_signed_divider_if
   import seq_signed_divider_pkg::*;
#(
   parameter int unsigned W = DEFAULT_W
);
   logic             start;
   logic [2*W-1:0]   dividend;
   logic [W-1:0]     divisor;
   logic             busy;
   logic             done;
   logic [W-1:0]     quotient;
   logic [W-1:0]     remainder;
   logic             div_by_zero;
   logic             overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/seq_signed_divider_twos_mag.sv
// Conditional two's-complement negate. With neg_i tied to the value's MSB it yields the
// unsigned magnitude (the most negative value maps to 2^(WD-1) and stays unsigned).
module seq_signed_divider_twos_mag #(
   parameter int unsigned WD = 32
) (
   input  logic [WD-1:0] value_i,
   input  logic          neg_i,
   output logic [WD-1:0] result_c_o
);

   assign result_c_o = neg_i ? (~value_i + WD'(1)) : value_i;

endmodule

// File: rtl/seq_signed_divider.sv
// Radix-2 restoring signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per cycle.
// Works on unsigned magnitudes throughout; signs are applied once in FIXUP.
module seq_signed_divider
   import seq_signed_divider_pkg::*;
#(
   parameter int unsigned W = DEFAULT_W
) (
   input  logic                clk_i,
   input  logic                reset_i,
   seq_signed_divider_if.slave bus
);

   localparam int unsigned DW = 2 * W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [W-1:0] OVF_Q = {1'b1, {(W-1){1'b0}}};

   state_t       state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  dmag_q, dmag_d;
   logic [W-1:0]  prem_q, prem_d;
   logic [W-1:0]  sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          ovf_pend_q, ovf_pend_d;
   logic [W-1:0]  res_quo_q, res_quo_d;
   logic [W-1:0]  res_rem_q, res_rem_d;
   div_flags_t    res_flags_q, res_flags_d;
   logic [W-1:0]  quotient_q, quotient_d;
   logic [W-1:0]  remainder_q, remainder_d;
   div_flags_t    flags_q, flags_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [DW-1:0] dvd_mag_c;
   logic [W-1:0]  dvs_mag_c;
   logic [W-1:0]  q_signed_c;
   logic [W-1:0]  r_signed_c;
   logic [W:0]    trial_c;
   logic          trial_ge_c;
   logic          q_range_ovf_c;

   seq_signed_divider_twos_mag #(.WD(DW)) u_dvd_mag (
      .value_i    (dvd_q),
      .neg_i      (dvd_q[DW-1]),
      .result_c_o (dvd_mag_c)
   );

   seq_signed_divider_twos_mag #(.WD(W)) u_dvs_mag (
      .value_i    (dvs_q),
      .neg_i      (dvs_q[W-1]),
      .result_c_o (dvs_mag_c)
   );

   seq_signed_divider_twos_mag #(.WD(W)) u_q_sign (
      .value_i    (sh_q),
      .neg_i      (qneg_q),
      .result_c_o (q_signed_c)
   );

   seq_signed_divider_twos_mag #(.WD(W)) u_r_sign (
      .value_i    (prem_q),
      .neg_i      (rneg_q),
      .result_c_o (r_signed_c)
   );

   // Next dividend bit enters from the low half, which doubles as the quotient shift register.
   assign trial_c    = {prem_q, sh_q[W-1]};
   assign trial_ge_c = (trial_c >= {1'b0, dmag_q});

   // A negative quotient may reach magnitude 2^(W-1); a positive one may not.
   assign q_range_ovf_c = qneg_q ? (sh_q[W-1] & (|sh_q[W-2:0])) : sh_q[W-1];

   always_comb begin
      state_d     = state_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      dmag_d      = dmag_q;
      prem_d      = prem_q;
      sh_d        = sh_q;
      cnt_d       = cnt_q;
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      ovf_pend_d  = ovf_pend_q;
      res_quo_d   = res_quo_q;
      res_rem_d   = res_rem_q;
      res_flags_d = res_flags_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      flags_d     = flags_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               dvd_d   = bus.dividend;
               dvs_d   = bus.divisor;
               flags_d = '0;
               state_d = ST_PREP;
            end
         end

         ST_PREP: begin
            qneg_d = dvd_q[DW-1] ^ dvs_q[W-1];
            rneg_d = dvd_q[DW-1];
            if (dvs_q == '0) begin
               res_quo_d   = '1;
               res_rem_d   = dvd_q[W-1:0];
               res_flags_d = '{div_by_zero: 1'b1, overflow: 1'b0};
               state_d     = ST_DONE;
            end else begin
               dmag_d      = dvs_mag_c;
               prem_d      = dvd_mag_c[DW-1:W];
               sh_d        = dvd_mag_c[W-1:0];
               ovf_pend_d  = (dvd_mag_c[DW-1:W] >= dvs_mag_c);
               cnt_d       = CW'(W - 1);
               res_flags_d = '0;
               state_d     = ST_ITER;
            end
         end

         ST_ITER: begin
            if (trial_ge_c) begin
               prem_d = W'(trial_c - {1'b0, dmag_q});
            end else begin
               prem_d = trial_c[W-1:0];
            end
            sh_d = {sh_q[W-2:0], trial_ge_c};
            if (cnt_q == '0) begin
               state_d = ST_FIXUP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_FIXUP: begin
            if (ovf_pend_q || q_range_ovf_c) begin
               res_quo_d   = OVF_Q;
               res_rem_d   = '0;
               res_flags_d = '{div_by_zero: 1'b0, overflow: 1'b1};
            end else begin
               res_quo_d   = q_signed_c;
               res_rem_d   = r_signed_c;
               res_flags_d = '0;
            end
            state_d = ST_DONE;
         end

         ST_DONE: begin
            quotient_d  = res_quo_q;
            remainder_d = res_rem_q;
            flags_d     = res_flags_q;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_PREP) || (state_d == ST_ITER) || (state_d == ST_FIXUP);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         dvd_q       <= '0;
         dvs_q       <= '0;
         dmag_q      <= '0;
         prem_q      <= '0;
         sh_q        <= '0;
         cnt_q       <= '0;
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
         ovf_pend_q  <= 1'b0;
         res_quo_q   <= '0;
         res_rem_q   <= '0;
         res_flags_q <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         flags_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         dmag_q      <= dmag_d;
         prem_q      <= prem_d;
         sh_q        <= sh_d;
         cnt_q       <= cnt_d;
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
         ovf_pend_q  <= ovf_pend_d;
         res_quo_q   <= res_quo_d;
         res_rem_q   <= res_rem_d;
         res_flags_q <= res_flags_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         flags_q     <= flags_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quotient_q;
   assign bus.remainder   = remainder_q;
   assign bus.div_by_zero = flags_q.div_by_zero;
   assign bus.overflow    = flags_q.overflow;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: signs, divide-by-zero, overflow edges, latency,
// ignored starts, mid-operation reset and a multiply/divide round trip.
module tb_seq_signed_divider;
   import seq_signed_divider_pkg::*;

   localparam int W       = DEFAULT_W;
   localparam int TIMEOUT = 200;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   seq_signed_divider_if #(.W(W)) bus ();

   seq_signed_divider #(.W(W)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and wait (bounded) for done; lat counts edges after the accept edge.
   task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dbz, output logic ovf,
                         output int lat, output int bcnt);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0; bcnt = 0;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         if (bus.busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      q = bus.quotient; r = bus.remainder; dbz = bus.div_by_zero; ovf = bus.overflow;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", bus.done); end
      n_vec++; if (bus.quotient !== '0) begin n_err++; $display("FAIL reset_q got %h exp 0", bus.quotient); end
      n_vec++; if (bus.remainder !== '0) begin n_err++; $display("FAIL reset_r got %h exp 0", bus.remainder); end
      n_vec++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b%b exp 00", bus.div_by_zero, bus.overflow); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      run_op(64'd100, 32'd7, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL basic_q got %h exp %h", q, 32'd14); end
      n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL basic_r got %h exp %h", r, 32'd2); end
      n_vec++; if ({dbz, ovf} !== 2'b00) begin n_err++; $display("FAIL basic_flags got %b%b exp 00", dbz, ovf); end
      n_vec++; if (lat !== W + 3) begin n_err++; $display("FAIL basic_latency got %0d exp %0d", lat, W + 3); end
      n_vec++; if (bcnt !== W + 2) begin n_err++; $display("FAIL basic_busy_cycles got %0d exp %0d", bcnt, W + 2); end
      @(posedge clk); #1;
      n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse got %b exp 0", bus.done); end
      n_vec++; if (bus.quotient !== 32'd14) begin n_err++; $display("FAIL basic_hold got %h exp %h", bus.quotient, 32'd14); end
   endtask

   task automatic test_signs();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'd7, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL negdvd_q got %h exp FFFFFFF2", q); end
      n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL negdvd_r got %h exp FFFFFFFE", r); end
      run_op(64'd100, 32'hFFFF_FFF9, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (q !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL negdvs_q got %h exp FFFFFFF2", q); end
      n_vec++; if (r !== 32'd2) begin n_err++; $display("FAIL negdvs_r got %h exp 2", r); end
      run_op(64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (q !== 32'd14) begin n_err++; $display("FAIL negboth_q got %h exp E", q); end
      n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL negboth_r got %h exp FFFFFFFE", r); end
      n_vec++; if ({dbz, ovf} !== 2'b00) begin n_err++; $display("FAIL negboth_flags got %b%b exp 00", dbz, ovf); end
   endtask

   task automatic test_div_zero();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      run_op(64'd100, 32'd0, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (q !== DIV0_QUOTIENT) begin n_err++; $display("FAIL div0_q got %h exp %h", q, DIV0_QUOTIENT); end
      n_vec++; if (r !== 32'd100) begin n_err++; $display("FAIL div0_r got %h exp 64", r); end
      n_vec++; if ({dbz, ovf} !== 2'b10) begin n_err++; $display("FAIL div0_flags got %b%b exp 10", dbz, ovf); end
      n_vec++; if (lat !== 2) begin n_err++; $display("FAIL div0_latency got %0d exp 2", lat); end
      n_vec++; if (bcnt !== 1) begin n_err++; $display("FAIL div0_busy_cycles got %0d exp 1", bcnt); end
      run_op(64'hFFFF_FFFF_FFFF_FFFB, 32'd0, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if (r !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL div0_neg_r got %h exp FFFFFFFB", r); end
      n_vec++; if ({dbz, ovf} !== 2'b10) begin n_err++; $display("FAIL div0_neg_flags got %b%b exp 10", dbz, ovf); end
   endtask

   task automatic test_overflow();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      run_op(64'h0000_0100_0000_0000, 32'd1, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {OVF_QUOTIENT, 32'd0, 2'b01}) begin n_err++; $display("FAIL ovf_2p40 got q=%h r=%h f=%b%b exp q=80000000 r=0 f=01", q, r, dbz, ovf); end
      n_vec++; if (lat !== W + 3) begin n_err++; $display("FAIL ovf_latency got %0d exp %0d", lat, W + 3); end
      run_op(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {OVF_QUOTIENT, 32'd0, 2'b01}) begin n_err++; $display("FAIL ovf_min_by_m1 got q=%h r=%h f=%b%b exp q=80000000 r=0 f=01", q, r, dbz, ovf); end
      run_op(64'hFFFF_FFFF_0000_0000, 32'd2, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {32'h8000_0000, 32'd0, 2'b00}) begin n_err++; $display("FAIL min_quotient got q=%h r=%h f=%b%b exp q=80000000 r=0 f=00", q, r, dbz, ovf); end
      run_op(64'hFFFF_FFFF_8000_0000, 32'd1, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {32'h8000_0000, 32'd0, 2'b00}) begin n_err++; $display("FAIL min_by_1 got q=%h r=%h f=%b%b exp q=80000000 r=0 f=00", q, r, dbz, ovf); end
      run_op(64'h0000_0000_7FFF_FFFF, 32'd1, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {32'h7FFF_FFFF, 32'd0, 2'b00}) begin n_err++; $display("FAIL max_by_1 got q=%h r=%h f=%b%b exp q=7FFFFFFF r=0 f=00", q, r, dbz, ovf); end
      run_op(64'h0000_0000_FFFF_FFFF, 32'd1, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {OVF_QUOTIENT, 32'd0, 2'b01}) begin n_err++; $display("FAIL range_ovf got q=%h r=%h f=%b%b exp q=80000000 r=0 f=01", q, r, dbz, ovf); end
   endtask

   task automatic test_ignored_start();
      int lat;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 64'd1000; bus.divisor = 32'd10;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < TIMEOUT) begin
         if (lat == 3 || lat == 10 || lat == W + 2) begin
            bus.start = 1'b1; bus.dividend = 64'd777; bus.divisor = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      n_vec++; if ({bus.quotient, bus.remainder} !== {32'd100, 32'd0}) begin n_err++; $display("FAIL ignore_start_result got q=%h r=%h exp q=64 r=0", bus.quotient, bus.remainder); end
      n_vec++; if (lat !== W + 3) begin n_err++; $display("FAIL ignore_start_latency got %0d exp %0d", lat, W + 3); end
      @(posedge clk); #1;
      n_vec++; if ({bus.busy, bus.done} !== 2'b00) begin n_err++; $display("FAIL ignore_start_queued got busy=%b done=%b exp 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      run_op(64'd123456789, 32'd1000, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r} !== {32'd123456, 32'd789}) begin n_err++; $display("FAIL b2b_first got q=%0d r=%0d exp q=123456 r=789", q, r); end
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'd2, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {32'd0, 32'hFFFF_FFFF, 2'b00}) begin n_err++; $display("FAIL b2b_second got q=%h r=%h f=%b%b exp q=0 r=FFFFFFFF f=00", q, r, dbz, ovf); end
   endtask

   task automatic test_abort_reset();
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt, ndone;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.dividend = 64'd5000; bus.divisor = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_vec++; if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== '0) begin n_err++; $display("FAIL abort_outputs got busy=%b done=%b q=%h r=%h f=%b%b exp all 0", bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow); end
      ndone = 0;
      for (int i = 0; i < W + 6; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      end
      n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL abort_no_done got %0d active cycles exp 0", ndone); end
      run_op(64'd5000, 32'd7, q, r, dbz, ovf, lat, bcnt);
      n_vec++; if ({q, r, dbz, ovf} !== {32'd714, 32'd2, 2'b00}) begin n_err++; $display("FAIL abort_next_op got q=%0d r=%0d f=%b%b exp q=714 r=2 f=00", q, r, dbz, ovf); end
   endtask

   task automatic test_round_trip();
      logic signed [W-1:0]   a, b;
      logic signed [2*W-1:0] a_ext, b_ext, p;
      logic [W-1:0] q, r; logic dbz, ovf; int lat, bcnt;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 3 == 0) b = b >>> 20;
         if (i % 5 == 1) a = a >>> 16;
         if (b == 0) b = 1;
         a_ext = a;
         b_ext = b;
         p = a_ext * b_ext;
         run_op(p, b, q, r, dbz, ovf, lat, bcnt);
         n_vec++;
         if (lat >= TIMEOUT || q !== a || r !== '0 || {dbz, ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL round_trip a=%h b=%h got q=%h r=%h f=%b%b lat=%0d exp q=%h r=0 f=00", a, b, q, r, dbz, ovf, lat, a);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_overflow();
      test_ignored_start();
      test_back_to_back();
      test_abort_reset();
      test_round_trip();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
